hdd_sd_bridge: RTL and testbench
================================

Name: hdd_sd_bridge

Overview:
Handshake bridge between the IIgs core's hard-disk sector requests and the HPS virtual-disk channel 0.
- Latches single-cycle read/write request pulses and the core's LBA.
- Drives level sd_rd/sd_wr until the HPS acknowledges, and holds cpu_wait across the whole transfer.
- Tracks mount/write-protect state and rejects illegal requests.
- Sits between the iigs core (HDD_READ/HDD_WRITE/HDD_SECTOR) and hps_io (sd_rd[0]/sd_wr[0]/sd_ack[0]/sd_lba[0]).

Parameters:
TIMEOUT_CYCLES, 28636364, clk_sys cycles allowed from request issue to ack falling edge (1 s at 28.636 MHz); used only with the optional feature.
SECTOR_BYTES, 512, expected sd_buff_wr beats per sector.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hdd_read  in  1  one-cycle read request pulse from core
hdd_write  in  1  one-cycle write request pulse from core
hdd_lba_in  in  32  sector number from core, sampled on request pulse
img_mounted  in  1  one-cycle mount event from hps_io
img_size_nz  in  1  image size non-zero, valid with img_mounted
img_readonly  in  1  image read-only flag, valid with img_mounted
sd_ack  in  1  HPS transfer acknowledge (level)
sd_buff_wr  in  1  HPS buffer write strobe (qualified internally by sd_ack)
sd_rd  out  1  read request to HPS
sd_wr  out  1  write request to HPS
sd_lba  out  32  latched sector to HPS
cpu_wait  out  1  stall to core
hdd_mounted  out  1  image present
hdd_protect  out  1  image write-protected
xfer_done  out  1  one-cycle pulse on successful completion
xfer_error  out  1  one-cycle pulse on rejected or timed-out request
beat_count  out  10  sd_buff_wr beats seen in the current/last transfer (0..512)

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags cleared. The async assert is honoured mid-transfer: sd_rd/sd_wr drop immediately, no done/error pulse.
- Mount: on img_mounted, hdd_mounted<=img_size_nz and hdd_protect<=img_readonly. Takes effect in any state and does not abort an active transfer.
- Pending latches rd_pend and wr_pend, one deep each:
  - Set by the corresponding pulse in any state.
  - Repeat pulses while pending coalesce; the LBA of the latest pulse wins.
  - Separate 32-bit LBA latches are kept for read and write.
- Request pulse and pending-clear in the same cycle: the pulse wins (pending stays set).
- State machine:
  - IDLE:
    - If rd_pend: read has priority over write. If !hdd_mounted: clear it, pulse xfer_error, stay IDLE. Otherwise sd_lba<=rd LBA, sd_rd<=1, cpu_wait<=1, beat_count<=0, go to ISSUE.
    - Else if wr_pend: if !hdd_mounted or hdd_protect, clear it, pulse xfer_error, stay IDLE. Otherwise same as the read path with sd_wr<=1.
  - ISSUE: on sd_ack rising edge (registered old_ack), clear sd_rd/sd_wr and the serviced pending flag, go to ACTIVE.
  - ACTIVE: beat_count increments on sd_buff_wr&sd_ack and saturates at SECTOR_BYTES. On sd_ack falling edge, go to FINISH.
  - FINISH: one cycle. cpu_wait<=0, xfer_done<=1, go to IDLE. The next pending request may issue on the following cycle.
- Latency:
  - Pulse at cycle N → pending at N+1 → sd_rd/sd_wr and cpu_wait high at N+2.
  - cpu_wait falls the cycle after FINISH is entered, i.e. 2 cycles after the sd_ack falling edge.
- sd_ack already high on entry to ISSUE: wait for a clean rising edge (no false accept).
- sd_ack pulse of a single cycle: rise and fall are handled on consecutive cycles. Completion is still a valid xfer_done.
- hdd_read and hdd_write in the same cycle: both latched; read serviced first, write immediately after.

Optional Feature:
HDD_BRIDGE_TIMEOUT_EN.
- Enabled:
  - A 25-bit counter clears on entry to ISSUE and counts in ISSUE/ACTIVE.
  - Reaching TIMEOUT_CYCLES-1: drop sd_rd/sd_wr, clear the serviced pending flag, cpu_wait<=0, pulse xfer_error, return to IDLE.
  - A late sd_ack afterwards is ignored until its falling edge.
- Disabled: no counter; the bridge waits for sd_ack indefinitely.

Decomposition:
- Package hdd_bridge_pkg holds:
  - State enum: IDLE, ISSUE, ACTIVE, FINISH.
  - SECTOR_BYTES_DEF=512.
  - TIMEOUT_DEF=28636364.
  - Counter width localparams.
- One natural sub-module, hdd_req_latch: one pending flag plus its LBA register, instantiated twice (read, write).

Test Plan:
1. Mounted, rw image; hdd_read pulse with LBA 0x00000123 → sd_rd=1 and sd_lba=0x123 two cycles later; HPS acks, sends 512 beats, releases → beat_count=512, xfer_done pulse, cpu_wait low 2 cycles after ack fall.
2. Mounted, img_readonly=1; hdd_write pulse → no sd_wr, xfer_error pulse, cpu_wait stays 0.
3. hdd_read and hdd_write in the same cycle (LBA 5) → read transfer completes first, then sd_wr asserts the cycle after FINISH; two xfer_done pulses.
4. Two hdd_read pulses during an active write (LBAs 7 then 9) → one read issued after the write, sd_lba=9.
5. reset_n low in ACTIVE → sd_rd, sd_wr, cpu_wait, xfer_done all 0 asynchronously; after release no pending requests.
6. With HDD_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100, sd_ack never asserted → xfer_error pulse at cycle 100 after issue, sd_rd=0, cpu_wait=0.

Source files
------------

// File: rtl/hdd_bridge_pkg.sv
// Shared types and constants for the hdd_sd_bridge block.
package hdd_bridge_pkg;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int SECTOR_BYTES_DEF = 512;
    localparam int TIMEOUT_DEF      = 28636364;

    // 10 bits hold 0..512 beats; 25 bits hold one second of clk_sys cycles
    localparam int BEAT_W = 10;
    localparam int TMO_W  = 25;
    localparam int LBA_W  = 32;

endpackage

// File: rtl/hdd_sd_bridge_if.sv
// HPS virtual-disk channel 0 handshake: request levels, LBA, ack and buffer strobe.
interface hdd_sd_bridge_if;
    import hdd_bridge_pkg::*;

    logic             sd_rd;
    logic             sd_wr;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_ack;
    logic             sd_buff_wr;

    // Bridge side: issues requests, receives acknowledge and data strobes
    modport master (
        output sd_rd,
        output sd_wr,
        output sd_lba,
        input  sd_ack,
        input  sd_buff_wr
    );

    // HPS side: services requests
    modport slave (
        input  sd_rd,
        input  sd_wr,
        input  sd_lba,
        output sd_ack,
        output sd_buff_wr
    );

endinterface

// File: rtl/hdd_req_latch.sv
// One-deep pending request flag with its sector register.
// A new pulse always wins over a clear in the same cycle, and repeat
// pulses coalesce with the latest LBA kept.
module hdd_req_latch
    import hdd_bridge_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             i_pulse,
    input  logic [LBA_W-1:0] i_lba,
    input  logic             i_clr,
    output logic             o_pend,
    output logic [LBA_W-1:0] o_lba
);

    logic             r_pend;
    logic [LBA_W-1:0] r_lba;

    // Capture request pulse and LBA; clear only when no new pulse arrives
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 1'b0;
            r_lba  <= '0;
        end else if (i_pulse) begin
            r_pend <= 1'b1;
            r_lba  <= i_lba;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_lba  = r_lba;

endmodule

// File: rtl/hdd_sd_bridge.sv
// Bridge between the IIgs core hard-disk sector requests and hps_io
// virtual-disk channel 0. Latches request pulses, holds sd_rd/sd_wr until
// the HPS acknowledges, stalls the core for the whole transfer and rejects
// requests that the current mount state does not allow.
// Optional build macro HDD_BRIDGE_TIMEOUT_EN adds a request-to-completion
// watchdog of TIMEOUT_CYCLES clk_sys cycles.
module hdd_sd_bridge
    import hdd_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int SECTOR_BYTES   = SECTOR_BYTES_DEF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               hdd_read,
    input  logic               hdd_write,
    input  logic [LBA_W-1:0]   hdd_lba_in,
    input  logic               img_mounted,
    input  logic               img_size_nz,
    input  logic               img_readonly,
    hdd_sd_bridge_if.master    sd,
    output logic               cpu_wait,
    output logic               hdd_mounted,
    output logic               hdd_protect,
    output logic               xfer_done,
    output logic               xfer_error,
    output logic [BEAT_W-1:0]  beat_count
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TMO_W)) begin : g_tmo_range
        $error("hdd_sd_bridge: TIMEOUT_CYCLES does not fit the watchdog counter");
    end

    state_t             r_state;
    logic               r_sd_rd;
    logic               r_sd_wr;
    logic [LBA_W-1:0]   r_sd_lba;
    logic               r_cpu_wait;
    logic               r_done;
    logic               r_err;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_old_ack;
    logic               r_is_wr;
    logic               r_mounted;
    logic               r_protect;

    state_t             w_state_nxt;
    logic               w_sd_rd_nxt;
    logic               w_sd_wr_nxt;
    logic [LBA_W-1:0]   w_sd_lba_nxt;
    logic               w_wait_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic               w_is_wr_nxt;
    logic               w_rd_clr;
    logic               w_wr_clr;
    logic               w_rd_pend;
    logic               w_wr_pend;
    logic [LBA_W-1:0]   w_rd_lba;
    logic [LBA_W-1:0]   w_wr_lba;
    logic               w_ack_rise;
    logic               w_ack_fall;

`ifdef HDD_BRIDGE_TIMEOUT_EN
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;
`endif

    hdd_req_latch u_rd_latch (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pulse (hdd_read),
        .i_lba   (hdd_lba_in),
        .i_clr   (w_rd_clr),
        .o_pend  (w_rd_pend),
        .o_lba   (w_rd_lba)
    );

    hdd_req_latch u_wr_latch (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pulse (hdd_write),
        .i_lba   (hdd_lba_in),
        .i_clr   (w_wr_clr),
        .o_pend  (w_wr_pend),
        .o_lba   (w_wr_lba)
    );

    // Mount events update image state in any sequencing state
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mounted <= 1'b0;
            r_protect <= 1'b0;
        end else if (img_mounted) begin
            r_mounted <= img_size_nz;
            r_protect <= img_readonly;
        end
    end

    assign w_ack_rise = sd.sd_ack & ~r_old_ack;
    assign w_ack_fall = ~sd.sd_ack & r_old_ack;

    // Next-state and registered-output decode for the transfer sequencer
    always_comb begin
        w_state_nxt  = r_state;
        w_sd_rd_nxt  = r_sd_rd;
        w_sd_wr_nxt  = r_sd_wr;
        w_sd_lba_nxt = r_sd_lba;
        w_wait_nxt   = r_cpu_wait;
        w_beat_nxt   = r_beat;
        w_is_wr_nxt  = r_is_wr;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_rd_clr     = 1'b0;
        w_wr_clr     = 1'b0;
`ifdef HDD_BRIDGE_TIMEOUT_EN
        w_tmo_nxt    = r_tmo;
`endif

        unique case (r_state)
            IDLE: begin
                // Reads take priority; the pending flag is held until ack rise
                if (w_rd_pend) begin
                    if (!r_mounted) begin
                        w_rd_clr  = 1'b1;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_sd_lba_nxt = w_rd_lba;
                        w_sd_rd_nxt  = 1'b1;
                        w_wait_nxt   = 1'b1;
                        w_beat_nxt   = '0;
                        w_is_wr_nxt  = 1'b0;
                        w_state_nxt  = ISSUE;
`ifdef HDD_BRIDGE_TIMEOUT_EN
                        w_tmo_nxt    = '0;
`endif
                    end
                end else if (w_wr_pend) begin
                    if (!r_mounted || r_protect) begin
                        w_wr_clr  = 1'b1;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_sd_lba_nxt = w_wr_lba;
                        w_sd_wr_nxt  = 1'b1;
                        w_wait_nxt   = 1'b1;
                        w_beat_nxt   = '0;
                        w_is_wr_nxt  = 1'b1;
                        w_state_nxt  = ISSUE;
`ifdef HDD_BRIDGE_TIMEOUT_EN
                        w_tmo_nxt    = '0;
`endif
                    end
                end
            end
            ISSUE: begin
                // Only a clean rising edge counts, so an ack left high is not accepted
                if (w_ack_rise) begin
                    w_sd_rd_nxt = 1'b0;
                    w_sd_wr_nxt = 1'b0;
                    w_rd_clr    = ~r_is_wr;
                    w_wr_clr    = r_is_wr;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sd.sd_buff_wr && sd.sd_ack && (r_beat < BEAT_W'(SECTOR_BYTES))) begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
                if (w_ack_fall) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_wait_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

`ifdef HDD_BRIDGE_TIMEOUT_EN
        // Watchdog overrides the sequencer; the pending flag is still set only in ISSUE
        if (r_state == ISSUE || r_state == ACTIVE) begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
            if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_sd_rd_nxt = 1'b0;
                w_sd_wr_nxt = 1'b0;
                w_wait_nxt  = 1'b0;
                w_err_nxt   = 1'b1;
                w_state_nxt = IDLE;
                if (r_state == ISSUE) begin
                    w_rd_clr = ~r_is_wr;
                    w_wr_clr = r_is_wr;
                end
            end
        end
`endif
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_sd_lba   <= '0;
            r_cpu_wait <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_beat     <= '0;
            r_old_ack  <= 1'b0;
            r_is_wr    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sd_rd    <= w_sd_rd_nxt;
            r_sd_wr    <= w_sd_wr_nxt;
            r_sd_lba   <= w_sd_lba_nxt;
            r_cpu_wait <= w_wait_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_beat     <= w_beat_nxt;
            r_old_ack  <= sd.sd_ack;
            r_is_wr    <= w_is_wr_nxt;
        end
    end

`ifdef HDD_BRIDGE_TIMEOUT_EN
    // Watchdog counter, cleared when a request is issued
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmo_nxt;
        end
    end
`endif

    assign sd.sd_rd    = r_sd_rd;
    assign sd.sd_wr    = r_sd_wr;
    assign sd.sd_lba   = r_sd_lba;
    assign cpu_wait    = r_cpu_wait;
    assign hdd_mounted = r_mounted;
    assign hdd_protect = r_protect;
    assign xfer_done   = r_done;
    assign xfer_error  = r_err;
    assign beat_count  = r_beat;

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Scoreboard bench for hdd_sd_bridge: directed scenarios plus randomized
// request mixes against a transaction-level model of the bridge rules.
module tb_hdd_sd_bridge;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_ERR  = 2;
    localparam int K_DONE = 3;

    localparam int M_NORMAL = 0;
    localparam int M_ABORT  = 1;
    localparam int M_NONE   = 2;

`ifdef HDD_BRIDGE_TIMEOUT_EN
    localparam int BIG_BEATS = 40;
`else
    localparam int BIG_BEATS = 512;
`endif

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        int mode;
        int delay;
        int beats;
    } hps_cmd_t;

    logic        clk;
    logic        reset_n;
    logic        hdd_read;
    logic        hdd_write;
    logic [31:0] hdd_lba_in;
    logic        img_mounted;
    logic        img_size_nz;
    logic        img_readonly;
    logic        cpu_wait;
    logic        hdd_mounted;
    logic        hdd_protect;
    logic        xfer_done;
    logic        xfer_error;
    logic [9:0]  beat_count;

    hdd_sd_bridge_if sd_if ();

    hdd_sd_bridge #(.TIMEOUT_CYCLES(100), .SECTOR_BYTES(512)) dut (
        .clk_sys      (clk),
        .reset_n      (reset_n),
        .hdd_read     (hdd_read),
        .hdd_write    (hdd_write),
        .hdd_lba_in   (hdd_lba_in),
        .img_mounted  (img_mounted),
        .img_size_nz  (img_size_nz),
        .img_readonly (img_readonly),
        .sd           (sd_if.master),
        .cpu_wait     (cpu_wait),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .xfer_done    (xfer_done),
        .xfer_error   (xfer_error),
        .beat_count   (beat_count)
    );

    int       n_chk  = 0;
    int       n_fail = 0;
    exp_t     exp_q[$];
    hps_cmd_t hps_q[$];
    bit       m_mounted = 0;
    bit       m_protect = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, required completion before 900us");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endfunction

    function automatic void exp_push(int k, logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Model: decide outcome of one request from mount state alone
    function automatic void expect_req(bit is_wr, logic [31:0] lba, int beats, int delay);
        hps_cmd_t c;
        if (!m_mounted || (is_wr && m_protect)) begin
            exp_push(K_ERR, 0);
        end else begin
            exp_push(is_wr ? K_WR : K_RD, lba);
            exp_push(K_DONE, (beats > 512) ? 512 : beats);
            c.mode  = M_NORMAL;
            c.delay = delay;
            c.beats = beats;
            hps_q.push_back(c);
        end
    endfunction

    task automatic ev(int kind, logic [31:0] val);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val 0x%0h, required no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind) check("event_value", val, e.val);
        end
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard
    logic p_rd = 0;
    logic p_wr = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            p_rd <= 0;
            p_wr <= 0;
        end else begin
            if (sd_if.sd_rd && !p_rd) begin
                ev(K_RD, sd_if.sd_lba);
                check("wait_on_issue", cpu_wait, 1);
            end
            if (sd_if.sd_wr && !p_wr) begin
                ev(K_WR, sd_if.sd_lba);
                check("wait_on_issue", cpu_wait, 1);
            end
            if (xfer_error) begin
                ev(K_ERR, 0);
                check("wait_on_error", cpu_wait, 0);
            end
            if (xfer_done) ev(K_DONE, {22'd0, beat_count});
            p_rd <= sd_if.sd_rd;
            p_wr <= sd_if.sd_wr;
        end
    end

    // HPS responder: acknowledges each request according to the queued command
    initial begin
        hps_cmd_t c;
        sd_if.sd_ack     = 0;
        sd_if.sd_buff_wr = 0;
        forever begin
            @(posedge clk); #1;
            if (reset_n && (sd_if.sd_rd || sd_if.sd_wr)) begin
                if (hps_q.size() == 0) c = '{M_NORMAL, 0, 1};
                else c = hps_q.pop_front();
                if (c.mode == M_NORMAL) begin
                    for (int d = 0; d < c.delay; d++) begin @(posedge clk); #1; end
                    sd_if.sd_ack = 1;
                    @(posedge clk); #1;
                    for (int b = 0; b < c.beats; b++) begin
                        if (($urandom % 4) == 0) begin @(posedge clk); #1; end
                        sd_if.sd_buff_wr = 1;
                        @(posedge clk); #1;
                        sd_if.sd_buff_wr = 0;
                    end
                    sd_if.sd_ack = 0;
                end else if (c.mode == M_ABORT) begin
                    sd_if.sd_ack = 1;
                    @(posedge clk); #1;
                    for (int b = 0; b < 2000 && reset_n; b++) begin
                        sd_if.sd_buff_wr = 1;
                        @(posedge clk); #1;
                        sd_if.sd_buff_wr = 0;
                    end
                    sd_if.sd_ack = 0;
                end else begin
                    for (int k = 0; k < 1000 && (sd_if.sd_rd || sd_if.sd_wr); k++) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    end

    task automatic mount(bit size_nz, bit ro);
        img_mounted  = 1;
        img_size_nz  = size_nz;
        img_readonly = ro;
        @(posedge clk); #1;
        img_mounted  = 0;
        m_mounted    = size_nz;
        m_protect    = ro;
        check("hdd_mounted", hdd_mounted, m_mounted);
        check("hdd_protect", hdd_protect, m_protect);
    endtask

    task automatic pulse(bit rd, bit wr, logic [31:0] lba);
        hdd_read   = rd;
        hdd_write  = wr;
        hdd_lba_in = lba;
        @(posedge clk); #1;
        hdd_read   = 0;
        hdd_write  = 0;
        hdd_lba_in = $urandom;
    endtask

    task automatic wait_idle(string nm);
        bit ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !cpu_wait && !sd_if.sd_rd && !sd_if.sd_wr && !sd_if.sd_ack) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got %0d events still outstanding, required bridge idle", nm, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        int op;
        logic [31:0] lba;
        reset_n = 0; hdd_read = 0; hdd_write = 0; hdd_lba_in = 0;
        img_mounted = 0; img_size_nz = 0; img_readonly = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sd_rd", sd_if.sd_rd, 0);
        check("reset_sd_wr", sd_if.sd_wr, 0);
        check("reset_cpu_wait", cpu_wait, 0);
        check("reset_mounted", hdd_mounted, 0);
        check("reset_beats", beat_count, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // 1: read latency, full sector, cpu_wait release timing
        mount(1, 0);
        expect_req(0, 32'h123, BIG_BEATS, 3);
        pulse(1, 0, 32'h123);
        check("t1_rd_not_yet", sd_if.sd_rd, 0);
        @(posedge clk); #1;
        check("t1_sd_rd", sd_if.sd_rd, 1);
        check("t1_sd_lba", sd_if.sd_lba, 32'h123);
        check("t1_cpu_wait", cpu_wait, 1);
        seen = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sd_if.sd_ack) seen = 1;
            else if (seen) break;
        end
        check("t1_ack_fell", {31'd0, seen && !sd_if.sd_ack}, 1);
        @(posedge clk); #1;
        check("t1_wait_hold", cpu_wait, 1);
        @(posedge clk); #1;
        check("t1_wait_release", cpu_wait, 0);
        check("t1_done", xfer_done, 1);
        wait_idle("t1_idle");

        // 2: write to protected image is rejected without a transfer
        mount(1, 1);
        expect_req(1, 32'h40, 4, 0);
        pulse(0, 1, 32'h40);
        for (int k = 0; k < 4; k++) begin
            check("t2_no_wr_wait", {30'd0, sd_if.sd_wr, cpu_wait}, 0);
            @(posedge clk); #1;
        end
        wait_idle("t2_idle");

        // 3: simultaneous read and write, write issues right after read completes
        mount(1, 0);
        expect_req(0, 32'd5, 6, 1);
        expect_req(1, 32'd5, 3, 2);
        pulse(1, 1, 32'd5);
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            if (xfer_done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("t3_first_done", {31'd0, seen}, 1);
        check("t3_wr_not_yet", sd_if.sd_wr, 0);
        @(posedge clk); #1;
        check("t3_wr_issue", sd_if.sd_wr, 1);
        wait_idle("t3_idle");

        // 4: reads coalesce during an active write, latest LBA wins
        exp_push(K_WR, 32'h77);
        exp_push(K_DONE, 30);
        hps_q.push_back('{M_NORMAL, 2, 30});
        exp_push(K_RD, 32'd9);
        exp_push(K_DONE, 4);
        hps_q.push_back('{M_NORMAL, 1, 4});
        pulse(0, 1, 32'h77);
        for (int k = 0; k < 50 && !sd_if.sd_ack; k++) @(negedge clk);
        @(posedge clk); #1;
        pulse(1, 0, 32'd7);
        @(posedge clk); #1;
        pulse(1, 0, 32'd9);
        wait_idle("t4_idle");

        // 5: asynchronous reset mid-transfer
        exp_push(K_RD, 32'h55);
        hps_q.push_back('{M_ABORT, 0, 0});
        pulse(1, 0, 32'h55);
        for (int k = 0; k < 50 && !sd_if.sd_ack; k++) @(negedge clk);
        repeat (8) @(posedge clk);
        #1;
        reset_n = 0;
        #1;
        check("t5_rd", sd_if.sd_rd, 0);
        check("t5_wr", sd_if.sd_wr, 0);
        check("t5_wait", cpu_wait, 0);
        check("t5_done", xfer_done, 0);
        check("t5_beats", beat_count, 0);
        check("t5_mounted", hdd_mounted, 0);
        m_mounted = 0;
        m_protect = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (4) @(posedge clk);
        #1;
        mount(1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_pending", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, 0);
        wait_idle("t5_idle");

`ifdef HDD_BRIDGE_TIMEOUT_EN
        // 6: no acknowledge, watchdog fires 100 cycles after issue
        exp_push(K_RD, 32'h66);
        exp_push(K_ERR, 0);
        hps_q.push_back('{M_NONE, 0, 0});
        pulse(1, 0, 32'h66);
        @(posedge clk); #1;
        check("t6_issue", sd_if.sd_rd, 1);
        repeat (99) @(posedge clk);
        #1;
        check("t6_no_err_early", xfer_error, 0);
        @(posedge clk); #1;
        check("t6_err", xfer_error, 1);
        check("t6_rd_drop", sd_if.sd_rd, 0);
        check("t6_wait_drop", cpu_wait, 0);
        wait_idle("t6_idle");
`endif

        // Randomized request mixes and mount changes
        for (int it = 0; it < 20; it++) begin
            int b1, b2;
            if (($urandom % 4) == 0) mount(($urandom % 4) != 0, ($urandom % 3) == 0);
            op  = $urandom % 3;
            lba = $urandom;
            b1  = (($urandom % 8) == 0) ? BIG_BEATS + $urandom_range(0, 12) : $urandom_range(0, 24);
            b2  = (($urandom % 8) == 0) ? BIG_BEATS + $urandom_range(0, 12) : $urandom_range(0, 24);
            if (op != 1) expect_req(0, lba, b1, $urandom_range(0, 5));
            if (op != 0) expect_req(1, lba, b2, $urandom_range(0, 5));
            pulse(op != 1, op != 0, lba);
            wait_idle("rand_idle");
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
